// File: rtl/quire_dot_sequencer_if.sv
// Operand stream, multiply/accumulate/convert control and result port
// bundle for quire_dot_sequencer.
interface quire_dot_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int LEN_BITS = 16
);
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                mul_issue;
    logic [WIDTH-1:0]    mul_a;
    logic [WIDTH-1:0]    mul_b;
    logic                acc_clear;
    logic                acc_en;
    logic                conv_start;
    logic [WIDTH-1:0]    conv_result;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [LEN_BITS-1:0] out_count;
    logic                out_ovf;
    logic                busy;

    modport slave (
        input  in_valid, in_last, in_a, in_b, conv_result, out_ready,
        output in_ready, mul_issue, mul_a, mul_b, acc_clear, acc_en,
        output conv_start, out_valid, out_data, out_count, out_ovf, busy
    );

    modport master (
        output in_valid, in_last, in_a, in_b, conv_result, out_ready,
        input  in_ready, mul_issue, mul_a, mul_b, acc_clear, acc_en,
        input  conv_start, out_valid, out_data, out_count, out_ovf, busy
    );
endinterface

// File: rtl/quire_dot_sequencer.sv
// Dot-product sequencer for a shared posit multiplier and quire datapath.
// Optional NaR tracking is enabled by defining QUIRE_NAR_TRACK_EN.
module quire_dot_sequencer #(
    parameter int WIDTH    = 8,
    parameter int ES       = 1,
    parameter int MUL_LAT  = 2,
    parameter int ACC_LAT  = 1,
    parameter int CONV_LAT = 3,
    parameter int LEN_BITS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    quire_dot_sequencer_if.slave  io
);

    if (MUL_LAT < 1 || ACC_LAT < 1 || CONV_LAT < 1 || ES < 0) begin : g_bad_cfg
        $error("quire_dot_sequencer: illegal latency or ES parameter");
    end

    typedef enum logic [2:0] {
        IDLE, CLEAR, STREAM, DRAIN, CONVERT, OUTPUT
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(MUL_LAT + ACC_LAT - 1);
    localparam logic [7:0] CONV_LAST  = 8'(CONV_LAT);
    localparam logic [LEN_BITS-1:0] CNT_MAX = {LEN_BITS{1'b1}};

    state_t state, state_n;
    logic [7:0] tmr;
    logic fire;
    logic mul_issue_q;
    logic [WIDTH-1:0] mul_a_q, mul_b_q, data_q;
    logic [MUL_LAT-1:0] acc_pipe;
    logic [LEN_BITS-1:0] count_q;
    logic ovf_q;
    logic capture;
    logic [WIDTH-1:0] capture_val;

    assign fire    = io.in_valid && (state == STREAM);
    assign capture = (state == CONVERT) && (tmr == CONV_LAST);

`ifdef QUIRE_NAR_TRACK_EN
    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};
    logic nar_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nar_q <= 1'b0;
        end else if (state == CLEAR) begin
            nar_q <= 1'b0;
        end else if (fire && (io.in_a == NAR || io.in_b == NAR)) begin
            nar_q <= 1'b1;
        end
    end

    assign capture_val = nar_q ? NAR : io.conv_result;
`else
    assign capture_val = io.conv_result;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (io.in_valid) state_n = CLEAR;
            CLEAR:   state_n = STREAM;
            STREAM:  if (fire && io.in_last) state_n = DRAIN;
            DRAIN:   if (tmr == DRAIN_LAST) state_n = CONVERT;
            CONVERT: if (tmr == CONV_LAST) state_n = OUTPUT;
            OUTPUT:  if (io.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_n;
            tmr   <= (state_n != state) ? 8'd0 : tmr + 8'd1;
        end
    end

    // acc_en trails mul_issue by the multiplier depth in every state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_issue_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_pipe    <= '0;
        end else begin
            mul_issue_q <= fire;
            if (fire) begin
                mul_a_q <= io.in_a;
                mul_b_q <= io.in_b;
            end
            acc_pipe[0] <= mul_issue_q;
            for (int i = 1; i < MUL_LAT; i++) begin
                acc_pipe[i] <= acc_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (state == CLEAR) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else if (fire) begin
                if (count_q == CNT_MAX) ovf_q <= 1'b1;
                else count_q <= count_q + 1'b1;
            end else if (state == OUTPUT && io.out_ready) begin
                ovf_q <= 1'b0;
            end
            if (capture) data_q <= capture_val;
        end
    end

    assign io.in_ready   = (state == STREAM);
    assign io.mul_issue  = mul_issue_q;
    assign io.mul_a      = mul_a_q;
    assign io.mul_b      = mul_b_q;
    assign io.acc_clear  = (state == CLEAR);
    assign io.acc_en     = acc_pipe[MUL_LAT-1];
    assign io.conv_start = (state == CONVERT) && (tmr == 8'd0);
    assign io.out_valid  = (state == OUTPUT);
    assign io.out_data   = data_q;
    assign io.out_count  = count_q;
    assign io.out_ovf    = ovf_q;
    assign io.busy       = (state != IDLE);

endmodule

// File: tb/tb_quire_dot_sequencer.sv
// Directed, table-driven bench for quire_dot_sequencer: timing of the
// control strobes, result capture, backpressure, saturation and reset.
module tb_quire_dot_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    quire_dot_sequencer_if #(.WIDTH(8), .LEN_BITS(16)) bus ();
    quire_dot_sequencer dut (.clock(clock), .reset(reset), .io(bus));

    quire_dot_sequencer_if #(.WIDTH(8), .LEN_BITS(3)) sbus ();
    quire_dot_sequencer #(.LEN_BITS(3)) sdut (
        .clock(clock), .reset(reset), .io(sbus));
    assign sbus.conv_result = 8'h11;

`ifdef QUIRE_NAR_TRACK_EN
    localparam logic [7:0] NAR_EXP = 8'h80;
`else
    localparam logic [7:0] NAR_EXP = 8'h33;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // conversion unit model: result valid exactly 3 cycles after conv_start
    logic [7:0] conv_val = 8'h00;
    logic [2:0] cpipe;
    always @(posedge clock or posedge reset) begin
        if (reset) cpipe <= 3'b000;
        else cpipe <= {cpipe[1:0], bus.conv_start};
    end
    assign bus.conv_result = cpipe[2] ? conv_val : 8'hEE;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int t0;
    bit rec = 0;
    int t_clr, i_first, i_last, i_cnt, a_first, a_last, a_cnt;
    int c_first, c_cnt, v_first;

    always @(negedge clock) begin
        if (rec) begin
            int r;
            r = cyc - t0;
            if (bus.acc_clear && t_clr < 0) t_clr = r;
            if (bus.mul_issue) begin
                if (i_first < 0) i_first = r;
                i_last = r;
                i_cnt++;
            end
            if (bus.acc_en) begin
                if (a_first < 0) a_first = r;
                a_last = r;
                a_cnt++;
            end
            if (bus.conv_start) begin
                if (c_first < 0) c_first = r;
                c_cnt++;
            end
            if (bus.out_valid && v_first < 0) v_first = r;
        end
    end

    typedef struct {
        int n;
        int stall_at;
        int stall_len;
        int hold;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] conv;
        logic [7:0] data;
        int clr, i0, i1, a0, a1, cv, ov;
    } vec_t;

    vec_t tbl[4];

    task automatic send_terms(input int n, input logic [7:0] a,
                              input logic [7:0] b, input int stall_at,
                              input int stall_len);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int guard;
            if (stall_len > 0 && i == stall_at) begin
                bus.in_valid = 1'b0;
                repeat (stall_len) begin
                    @(posedge clock);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_a = a;
            bus.in_b = b;
            bus.in_last = (i == n - 1);
            acc = 0;
            guard = 0;
            while (!acc && guard < 50) begin
                @(negedge clock);
                acc = bus.in_ready;
                @(posedge clock);
                #1;
                guard++;
            end
            if (!acc) chk("handshake_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        bit found;
        logic [7:0] d;
        logic [15:0] c;
        t_clr = -1; i_first = -1; i_last = -1; i_cnt = 0;
        a_first = -1; a_last = -1; a_cnt = 0;
        c_first = -1; c_cnt = 0; v_first = -1;
        conv_val = v.conv;
        bus.out_ready = (v.hold == 0);
        @(posedge clock);
        #1;
        t0 = cyc;
        rec = 1;
        send_terms(v.n, v.a, v.b, v.stall_at, v.stall_len);
        found = 0;
        for (int g = 0; g < 60; g++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                found = 1;
                break;
            end
        end
        chk({tag, " out_valid_seen"}, 32'(found), 1);
        chk({tag, " out_data"}, 32'(bus.out_data), 32'(v.data));
        chk({tag, " out_count"}, 32'(bus.out_count), 32'(v.n));
        chk({tag, " out_ovf"}, 32'(bus.out_ovf), 0);
        d = bus.out_data;
        c = bus.out_count;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clock);
            chk({tag, " hold_valid"}, 32'(bus.out_valid), 1);
            chk({tag, " hold_data"}, 32'(bus.out_data), 32'(d));
            chk({tag, " hold_count"}, 32'(bus.out_count), 32'(c));
            chk({tag, " hold_in_ready"}, 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        rec = 0;
        chk({tag, " idle_busy"}, 32'(bus.busy), 0);
        chk({tag, " idle_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, " t_acc_clear"}, 32'(t_clr), 32'(v.clr));
        chk({tag, " t_issue_first"}, 32'(i_first), 32'(v.i0));
        chk({tag, " t_issue_last"}, 32'(i_last), 32'(v.i1));
        chk({tag, " issue_count"}, 32'(i_cnt), 32'(v.n));
        chk({tag, " t_acc_first"}, 32'(a_first), 32'(v.a0));
        chk({tag, " t_acc_last"}, 32'(a_last), 32'(v.a1));
        chk({tag, " acc_count"}, 32'(a_cnt), 32'(v.n));
        chk({tag, " t_conv_start"}, 32'(c_first), 32'(v.cv));
        chk({tag, " conv_pulses"}, 32'(c_cnt), 1);
        chk({tag, " t_out_valid"}, 32'(v_first), 32'(v.ov));
    endtask

    initial begin
        bit ok;
        vec_t nv;
        bus.in_valid = 0; bus.in_last = 0; bus.in_a = 0; bus.in_b = 0;
        bus.out_ready = 1;
        sbus.in_valid = 0; sbus.in_last = 0; sbus.in_a = 0; sbus.in_b = 0;
        sbus.out_ready = 1;

        tbl[0] = '{n:1, stall_at:0, stall_len:0, hold:0, a:8'h40, b:8'h40,
                   conv:8'h40, data:8'h40,
                   clr:1, i0:3, i1:3, a0:5, a1:5, cv:6, ov:10};
        tbl[1] = '{n:4, stall_at:0, stall_len:0, hold:0, a:8'h48, b:8'h38,
                   conv:8'h5C, data:8'h5C,
                   clr:1, i0:3, i1:6, a0:5, a1:8, cv:9, ov:13};
        tbl[2] = '{n:4, stall_at:2, stall_len:3, hold:0, a:8'h21, b:8'h52,
                   conv:8'h6A, data:8'h6A,
                   clr:1, i0:3, i1:9, a0:5, a1:11, cv:12, ov:16};
        tbl[3] = '{n:2, stall_at:0, stall_len:0, hold:5, a:8'h30, b:8'h44,
                   conv:8'h77, data:8'h77,
                   clr:1, i0:3, i1:4, a0:5, a1:6, cv:7, ov:11};

        repeat (3) @(posedge clock);
        #1;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst in_ready", 32'(bus.in_ready), 0);
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst mul_issue", 32'(bus.mul_issue), 0);
        chk("rst acc_en", 32'(bus.acc_en), 0);
        chk("rst out_data", 32'(bus.out_data), 0);
        chk("rst out_count", 32'(bus.out_count), 0);
        reset = 0;

        for (int t = 0; t < 4; t++) begin
            run_vec($sformatf("vec%0d", t), tbl[t]);
        end

        // abort a vector in DRAIN; previous result 8'h77 must vanish
        send_terms(3, 8'h5A, 8'h3C, 0, 0);
        reset = 1;
        #1;
        chk("mid_rst busy", 32'(bus.busy), 0);
        chk("mid_rst mul_issue", 32'(bus.mul_issue), 0);
        chk("mid_rst mul_a", 32'(bus.mul_a), 0);
        chk("mid_rst mul_b", 32'(bus.mul_b), 0);
        chk("mid_rst acc_en", 32'(bus.acc_en), 0);
        chk("mid_rst out_data", 32'(bus.out_data), 0);
        chk("mid_rst out_count", 32'(bus.out_count), 0);
        chk("mid_rst conv_start", 32'(bus.conv_start), 0);
        @(posedge clock);
        #1;
        reset = 0;
        ok = 1;
        repeat (4) begin
            @(negedge clock);
            if (bus.acc_en || bus.mul_issue || bus.busy) ok = 0;
        end
        chk("post_rst quiet", 32'(ok), 1);

        nv = '{n:2, stall_at:0, stall_len:0, hold:0, a:8'h40, b:8'h80,
               conv:8'h33, data:NAR_EXP,
               clr:1, i0:3, i1:4, a0:5, a1:6, cv:7, ov:11};
        run_vec("nar", nv);

        // LEN_BITS=3 instance: ten terms saturate the counter at 7
        @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            bit acc;
            int guard;
            sbus.in_valid = 1;
            sbus.in_a = 8'(8'h10 + i);
            sbus.in_b = 8'h40;
            sbus.in_last = (i == 9);
            acc = 0;
            guard = 0;
            while (!acc && guard < 50) begin
                @(negedge clock);
                acc = sbus.in_ready;
                @(posedge clock);
                #1;
                guard++;
            end
            if (!acc) chk("sat handshake_timeout", 0, 1);
        end
        sbus.in_valid = 0;
        sbus.in_last = 0;
        ok = 0;
        for (int g = 0; g < 60; g++) begin
            @(negedge clock);
            if (sbus.out_valid) begin
                ok = 1;
                break;
            end
        end
        chk("sat out_valid_seen", 32'(ok), 1);
        chk("sat out_count", 32'(sbus.out_count), 7);
        chk("sat out_ovf", 32'(sbus.out_ovf), 1);
        chk("sat out_data", 32'(sbus.out_data), 32'h11);
        @(negedge clock);
        chk("sat ovf_cleared", 32'(sbus.out_ovf), 0);
        chk("sat out_valid_drop", 32'(sbus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quire_dot_sequencer.md
Name: quire_dot_sequencer

Overview:
- Controller that sequences one shared posit multiplier and Kulisch (quire) accumulator datapath through a full dot product.
- Sequence: clear quire, stream operand pairs into the multiplier, drain the pipelines, trigger posit conversion, present the rounded result.
- Sits between an operand stream source (valid/ready/last) and the fixed-latency multiply/accumulate/convert units. Owns only control, counters and result registers; no arithmetic.

Parameters:
- WIDTH, 8, posit width in bits.
- ES, 1, posit exponent bits (informational; passed through for datapath instantiation).
- MUL_LAT, 2, posit multiplier pipeline depth in cycles (>=1).
- ACC_LAT, 1, quire accumulate latency in cycles (>=1).
- CONV_LAT, 3, quire-to-posit conversion latency in cycles (>=1).
- LEN_BITS, 16, width of the term counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted this cycle when in_valid && in_ready
- in_last  in  1  final pair of the vector
- in_a  in  WIDTH  posit operand A
- in_b  in  WIDTH  posit operand B
- mul_issue  out  1  multiplier input valid
- mul_a  out  WIDTH  registered operand A to multiplier
- mul_b  out  WIDTH  registered operand B to multiplier
- acc_clear  out  1  one-cycle quire clear
- acc_en  out  1  accumulate enable = mul_issue delayed MUL_LAT cycles
- conv_start  out  1  one-cycle conversion start
- conv_result  in  WIDTH  converted posit, valid CONV_LAT cycles after conv_start
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_data  out  WIDTH  dot-product posit result
- out_count  out  LEN_BITS  number of terms accumulated
- out_ovf  out  1  term counter saturated
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; every output 0, including mul_a/mul_b/out_data/out_count; acc_en delay line flushed; all counters 0. Reset mid-operation abandons the vector silently.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, CONVERT, OUTPUT.
- IDLE: in_ready=0. in_valid=1 -> CLEAR. The pair is not consumed.
- CLEAR: one cycle, acc_clear=1, term counter cleared -> STREAM.
- STREAM: in_ready=1.
  - Each handshake registers in_a/in_b into mul_a/mul_b, asserts mul_issue the next cycle, and increments the term counter.
  - The term counter saturates at 2^LEN_BITS-1 and sets the sticky out_ovf.
  - in_valid=0 stalls with no issue.
  - Handshake with in_last=1 -> DRAIN.
- DRAIN: in_ready=0; waits MUL_LAT+ACC_LAT cycles so the last acc_en and its accumulation complete -> CONVERT.
- CONVERT: conv_start=1 on the first cycle only. Stays CONV_LAT+1 cycles. On the final cycle, conv_result is captured into out_data -> OUTPUT.
- OUTPUT: out_valid=1; out_data, out_count and out_ovf are held stable.
  - out_ready=1 -> IDLE next cycle; out_valid drops and out_ovf clears.
  - out_valid is never retracted without a handshake.
- acc_en is a MUL_LAT-deep shift register of mul_issue. It runs in every state, so in-flight products always complete before conv_start.
- Latency with defaults, no stalls, N terms, first in_valid at cycle 0:
  - first handshake at cycle 2; last handshake at cycle N+1;
  - conv_start at cycle N+5; out_valid at cycle N+9.
- Single-term vector (in_last on first pair) is legal.
- in_last is ignored outside STREAM.

Optional Feature:
- Macro: QUIRE_NAR_TRACK_EN.
- Defined: a sticky nar flag is set when an accepted in_a or in_b equals NaR (1 followed by WIDTH-1 zeros).
  - In OUTPUT, out_data is forced to NaR regardless of conv_result.
  - Flag clears in CLEAR and on reset.
- Undefined: no NaR detection; out_data = captured conv_result.

Test Plan:
- Single term: defaults, in_a=8'h40, in_b=8'h40, in_last=1, out_ready=1, conv_result driven 8'h40 -> acc_clear@1, mul_issue@3, acc_en@5, conv_start@6, out_valid@10, out_data=8'h40, out_count=1.
- Four terms, no stalls: pairs at cycles 2..5 -> mul_issue high cycles 3..6, acc_en cycles 5..8, conv_start@9, out_valid@13, out_count=4.
- Input stalls: in_valid low for 3 cycles between terms 2 and 3 of 4 -> no mul_issue during the gap, out_count=4, conv_start 3 cycles later than the no-stall case.
- Output backpressure: out_ready=0 for 5 cycles -> out_valid, out_data, out_count stable; in_ready=0; IDLE one cycle after out_ready=1.
- Saturation: LEN_BITS=3, 10 terms -> out_count=7, out_ovf=1; out_ovf=0 after the output handshake.
- Reset mid-DRAIN: reset asserted one cycle -> all outputs 0 immediately, acc_en flushed, busy=0. With QUIRE_NAR_TRACK_EN, a subsequent vector containing in_b=8'h80 -> out_data=8'h80.
